// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared scan-state encoding and active-low hex segment table.
//  Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  typedef enum logic [0:0] {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // {g,f,e,d,c,b,a} active low; entry 15 (F) first, entry 0 last
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage
`default_nettype wire

// File: rtl/seg7_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_ctrl_if
//  Purpose  : Load/display bundle between a host and the 7-segment scanner.
//  Revision : 1.0 - initial release
// ============================================================================
interface seg7_scan_ctrl_if;
  logic        load;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic [7:0]  digit_en;
  logic [2:0]  sel;
  logic [6:0]  seg;
  logic        dp;
  logic        blank;
  logic        frame;

  modport master (
    output load, data_in, dp_in, digit_en,
    input  sel, seg, dp, blank, frame
  );

  modport slave (
    input  load, data_in, dp_in, digit_en,
    output sel, seg, dp, blank, frame
  );
endinterface
`default_nettype wire

// File: rtl/hex7seg.sv
`default_nettype none
// ============================================================================
//  Module   : hex7seg
//  Purpose  : Combinational 4-bit hex to active-low {g..a} segment decoder.
//  Revision : 1.0 - initial release
// ============================================================================
module hex7seg
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_ctrl
//  Purpose  : 8-digit multiplexed display scanner with inter-digit blanking
//             and frame-synchronous data commit.
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  seg7_scan_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] c_show_last  = CNT_W'(REFRESH_DIV - BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_blank_last = CNT_W'(BLANK_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_sel, w_sel_nxt;
  logic [31:0]      r_disp_data, r_pend_data;
  logic [7:0]       r_disp_dp, r_pend_dp;
  logic             r_pend_valid;
  logic             w_boundary;
  logic [3:0]       w_nibble;
  logic [6:0]       w_hex_seg;
  logic             w_show_on;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_BLANK;
      r_cnt   <= '0;
      r_sel   <= 3'd7;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_sel_nxt   = r_sel;
    unique case (r_state)
      ST_SHOW: begin
        if (r_cnt == c_show_last) begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
        end
      end
      ST_BLANK: begin
        if (r_cnt == c_blank_last) begin
          w_state_nxt = ST_SHOW;
          w_cnt_nxt   = '0;
          w_sel_nxt   = r_sel + 3'd1;
        end
      end
    endcase
  end

  // Commit only when slot 7's blank ends so a frame never mixes two values
  assign w_boundary = (r_state == ST_BLANK) && (r_cnt == c_blank_last) && (r_sel == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_disp_data  <= '0;
      r_disp_dp    <= '0;
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
    end else if (w_boundary) begin
      if (bus.load) begin
        r_disp_data  <= bus.data_in;
        r_disp_dp    <= bus.dp_in;
        r_pend_valid <= 1'b0;
      end else if (r_pend_valid) begin
        r_disp_data  <= r_pend_data;
        r_disp_dp    <= r_pend_dp;
        r_pend_valid <= 1'b0;
      end
    end else if (bus.load) begin
      r_pend_data  <= bus.data_in;
      r_pend_dp    <= bus.dp_in;
      r_pend_valid <= 1'b1;
    end
  end

  assign w_nibble  = r_disp_data[{r_sel, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .nibble (w_nibble),
    .seg    (w_hex_seg)
  );

  assign w_show_on = (r_state == ST_SHOW) && bus.digit_en[r_sel];

  assign bus.sel   = r_sel;
  assign bus.seg   = w_show_on ? w_hex_seg : SEG_OFF;
  assign bus.dp    = w_show_on ? ~r_disp_dp[r_sel] : 1'b1;
  assign bus.blank = (r_state == ST_BLANK);
  assign bus.frame = (r_state == ST_SHOW) && (r_sel == 3'd0) && (r_cnt == '0);

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_ctrl
//  Purpose  : Scoreboard bench for seg7_scan_ctrl (slot = 8 SHOW + 2 BLANK).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg7_scan_ctrl_if bus ();

  seg7_scan_ctrl #(
    .REFRESH_DIV  (10),
    .BLANK_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] sel;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Posedges since reset release; cyc == P right after the P-th edge
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input int base, input logic [7:0][6:0] segs,
                            input logic [7:0] dpv, input int n);
    exp_t e;
    for (int j = 0; j < n; j++) begin
      e.cyc = base + 10 * j;
      e.sel = 3'(j);
      e.seg = segs[j];
      e.dp  = dpv[j];
      q.push_back(e);
    end
  endtask

  // Monitor: one pop per slot start (falling blank); blank windows always dark
  logic prev_blank = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_blank = 1'b1;
    end else begin
      if (prev_blank && !bus.blank) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL slot_unexpected actual=sel%0d expected=none (cyc %0d)", bus.sel, cyc);
        end else begin
          e = q.pop_front();
          chk("slot_cyc",   32'(cyc),       32'(e.cyc));
          chk("slot_sel",   32'(bus.sel),   32'(e.sel));
          chk("slot_seg",   32'(bus.seg),   32'(e.seg));
          chk("slot_dp",    32'(bus.dp),    32'(e.dp));
          chk("slot_frame", 32'(bus.frame), 32'(e.sel == 3'd0));
        end
      end else if (bus.frame) begin
        chk("frame_stray", 32'(bus.frame), 32'd0);
      end
      if (bus.blank) begin
        chk("blank_seg", 32'(bus.seg), 32'h7F);
        chk("blank_dp",  32'(bus.dp),  32'd1);
      end
      prev_blank = bus.blank;
    end
  end

  task automatic at(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
    #1;
  endtask

  task automatic do_load(input int c, input logic [31:0] d, input logic [7:0] dpv);
    at(c - 1);
    bus.load    = 1'b1;
    bus.data_in = d;
    bus.dp_in   = dpv;
    at(c);
    bus.load    = 1'b0;
    bus.dp_in   = 8'h00;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_sel",   32'(bus.sel),   32'd7);
    chk("rst_seg",   32'(bus.seg),   32'h7F);
    chk("rst_dp",    32'(bus.dp),    32'd1);
    chk("rst_blank", 32'(bus.blank), 32'd1);
    chk("rst_frame", 32'(bus.frame), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.load     = 1'b0;
    bus.data_in  = 32'h0;
    bus.dp_in    = 8'h00;
    bus.digit_en = 8'hFF;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Frame 0: cleared display, first slot 2 cycles after release
    push_frame(2, {8{7'h40}}, 8'hFF, 8);
    do_load(25, 32'h89ABCDEF, 8'h00);

    // Frame 1: nibbles F,E,d,C,b,A,9,8 in slots 0..7
    at(80);
    push_frame(82, {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}, 8'hFF, 8);
    do_load(120, 32'h44444444, 8'h00);

    // Load on the boundary bypasses and discards the pending 4s
    at(160);
    push_frame(162, {8{7'h79}}, 8'hFF, 8);
    do_load(162, 32'h11111111, 8'h00);
    at(240);
    push_frame(242, {8{7'h79}}, 8'hFF, 8);

    // Last load in a frame wins
    do_load(260, 32'h22222222, 8'h00);
    do_load(300, 32'h33333333, 8'h00);
    at(320);
    push_frame(322, {8{7'h30}}, 8'hFF, 8);
    at(400);
    push_frame(402, {8{7'h30}}, 8'hFF, 8);

    // Slot 0 disabled, decimal point on slot 2
    do_load(420, 32'h00000000, 8'h04);
    at(480);
    bus.digit_en = 8'hFE;
    push_frame(482, {{7{7'h40}}, 7'h7F}, 8'hFB, 8);

    at(560);
    bus.digit_en = 8'hFF;
    push_frame(562, {8{7'h40}}, 8'hFB, 5);

    // Reset mid slot 4 of frame 7
    at(605);
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    @(posedge clk);
    #2;
    rst = 1'b0;
    push_frame(2, {8{7'h40}}, 8'hFF, 8);
    at(80);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
